// File: rtl/ram_access_arbiter_if.sv
// rtl/ram_access_arbiter_if.sv - requester-side bundle of the shared RAM arbiter
interface ram_access_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port arbiter for the single-port program/data RAM
// Optional power-up zero fill of the RAM when RAM_SCRUB_EN is defined.
module ram_access_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    ram_access_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_wr,
    output logic              ram_en
);

`ifdef RAM_SCRUB_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, SCRUB} state_t;
    localparam state_t RESET_STATE = SCRUB;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    logic              last;
    logic              gnt1;
    logic [DATA_W-1:0] wdata_q;
    logic              pick1;

    // last records the most recent grant; on a tie the other port wins
    always_comb begin
        pick1 = bus.req1 && (!bus.req0 || (FIXED_PRIO == 0 && !last));
    end

    assign ram_data = ram_wr ? wdata_q : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_STATE;
            last      <= 1'b1;
            gnt1      <= 1'b0;
            wdata_q   <= '0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_en    <= 1'b0;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            bus.rdata <= '0;
            bus.busy  <= 1'b0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gnt1     <= pick1;
                        last     <= pick1;
                        ram_addr <= pick1 ? bus.addr1 : bus.addr0;
                        wdata_q  <= pick1 ? bus.wdata1 : bus.wdata0;
                        ram_wr   <= pick1 ? bus.wr1 : bus.wr0;
                        ram_en   <= pick1 ? !bus.wr1 : !bus.wr0;
                        bus.busy <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_en) begin
                        bus.rdata <= ram_data;
                    end
                    ram_wr   <= 1'b0;
                    ram_en   <= 1'b0;
                    bus.ack0 <= !gnt1;
                    bus.ack1 <= gnt1;
                    state    <= RESP;
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
`ifdef RAM_SCRUB_EN
                // ram_addr doubles as the scrub counter; first edge only arms the strobe
                SCRUB: begin
                    wdata_q <= '0;
                    if (!ram_wr) begin
                        ram_wr   <= 1'b1;
                        ram_addr <= '0;
                        bus.busy <= 1'b1;
                    end else if (ram_addr == '1) begin
                        ram_wr   <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - scoreboard bench for ram_access_arbiter
module tb_ram_access_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    wire  [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_wr, ram_en;

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr), .ram_en(ram_en)
    );

    logic [DW-1:0] mem [DEPTH];
    assign ram_data = ram_en ? mem[ram_addr] : 'z;
    always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_data;

    logic          req_d   [2];
    logic          wr_d    [2];
    logic [AW-1:0] addr_d  [2];
    logic [DW-1:0] wdata_d [2];
    assign bus.req0 = req_d[0];   assign bus.req1 = req_d[1];
    assign bus.wr0 = wr_d[0];     assign bus.wr1 = wr_d[1];
    assign bus.addr0 = addr_d[0]; assign bus.addr1 = addr_d[1];
    assign bus.wdata0 = wdata_d[0]; assign bus.wdata1 = wdata_d[1];

    // fixed-priority instance, writes only
    ram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_bus ();
    wire  [DW-1:0] fp_ram_data;
    logic [AW-1:0] fp_ram_addr;
    logic          fp_ram_wr, fp_ram_en;
    logic          fp_req0 = 1'b0, fp_req1 = 1'b0;
    assign fp_bus.req0 = fp_req0;  assign fp_bus.req1 = fp_req1;
    assign fp_bus.wr0 = 1'b1;      assign fp_bus.wr1 = 1'b1;
    assign fp_bus.addr0 = 4'd1;    assign fp_bus.addr1 = 4'd2;
    assign fp_bus.wdata0 = 8'h11;  assign fp_bus.wdata1 = 8'h22;
    assign fp_ram_data = fp_ram_en ? 8'h00 : 'z;

    ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .bus(fp_bus.slave),
        .ram_addr(fp_ram_addr), .ram_data(fp_ram_data), .ram_wr(fp_ram_wr), .ram_en(fp_ram_en)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // transaction-level reference: one access per three cycles, served in arbitration order
    typedef struct {int port; logic [DW-1:0] rdata; int cyc;} exp_t;
    exp_t          sb [$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_phase = 0;
    int            m_scrub = 0;
    int            m_win = 0;
    bit            m_last = 1'b1;
    logic [DW-1:0] m_rdata = '0;
    bit            m_pw_valid = 1'b0;
    logic [AW-1:0] m_pw_addr = '0;
    logic [DW-1:0] m_pw_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_last = 1'b1; m_rdata = '0; m_pw_valid = 1'b0;
            sb.delete();
`ifdef RAM_SCRUB_EN
            m_scrub = DEPTH + 1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`endif
        end else begin
            cyc++;
            if (m_scrub > 0) begin
                m_scrub--;
            end else if (m_phase > 0) begin
                if (m_phase == 2 && m_pw_valid) m_mem[m_pw_addr] = m_pw_data;
                m_phase--;
            end else if (req_d[0] || req_d[1]) begin
                if (req_d[0] && req_d[1]) m_win = m_last ? 0 : 1;
                else                      m_win = req_d[1] ? 1 : 0;
                m_last = (m_win == 1);
                m_pw_valid = wr_d[m_win];
                m_pw_addr  = addr_d[m_win];
                m_pw_data  = wdata_d[m_win];
                if (!wr_d[m_win]) m_rdata = m_mem[addr_d[m_win]];
                sb.push_back('{port: m_win, rdata: m_rdata, cyc: cyc + 1});
                m_phase = 2;
            end
        end
    end

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            automatic bit scrubbing = (m_scrub > 0 && m_scrub <= DEPTH);
            automatic exp_t e;
            chk("busy", bus.busy, (m_phase != 0) || scrubbing);
            chk("ram_wr", ram_wr, (m_phase == 2 && m_pw_valid) || scrubbing);
            chk("ram_en", ram_en, (m_phase == 2 && !m_pw_valid));
            if (m_phase == 2) chk("ram_addr", ram_addr, m_pw_addr);
            if (m_phase == 2 && m_pw_valid) chk("wr_data", ram_data, m_pw_data);
            if (scrubbing) begin
                chk("scrub_addr", ram_addr, DEPTH - m_scrub);
                chk("scrub_data", ram_data, 0);
            end
            if (bus.ack0 || bus.ack1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {bus.ack1, bus.ack0}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_both", bus.ack0 && bus.ack1, 0);
                    chk("ack_port", bus.ack1 ? 1 : 0, e.port);
                    chk("rdata", bus.rdata, e.rdata);
                    chk("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        req_d[p] = 1'b1; wr_d[p] = w; addr_d[p] = a; wdata_d[p] = d;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (p == 0 ? bus.ack0 : bus.ack1) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        @(posedge clk); #1;
        req_d[p] = 1'b0;
    endtask

    task automatic random_port(input int p, input int n);
        for (int t = 0; t < n; t++) begin
            int d = $urandom_range(0, 3);
            repeat (d) begin @(posedge clk); #1; end
            issue(p, 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom));
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ack0"}, bus.ack0, 0);
        chk({tag, "_ack1"}, bus.ack1, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ram_wr"}, ram_wr, 0);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
    endtask

    initial begin
        int n_ack0, n_ack1, lat;
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 1'b0; wr_d[i] = 1'b0; addr_d[i] = '0; wdata_d[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'h80 | 8'(i);
            m_mem[i] = 8'h80 | 8'(i);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
`ifdef RAM_SCRUB_EN
        issue(0, 1'b0, 4'd15, 8'h00);
`endif
        issue(1, 1'b1, 4'd3, 8'hA5);
        issue(0, 1'b0, 4'd3, 8'h00);

        fork
            begin issue(0, 1'b0, 4'd3, 8'h00); issue(0, 1'b1, 4'd4, 8'h5A); end
            begin issue(1, 1'b0, 4'd5, 8'h00); issue(1, 1'b0, 4'd4, 8'h00); end
        join

        fork
            random_port(0, 25);
            random_port(1, 25);
        join
        repeat (4) @(posedge clk);
        #1;

        // abort a write to addr 7 in its ACCESS cycle
        req_d[1] = 1'b1; wr_d[1] = 1'b1; addr_d[1] = 4'd7; wdata_d[1] = 8'h3C;
        @(posedge clk); #2;
        chk("pre_rst_wr", ram_wr, 1);
        rst = 1'b1;
        #1;
        reset_checks("abort");
        req_d[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 1'b0, 4'd7, 8'h00);
        issue(1, 1'b1, 4'd7, 8'h3C);
        issue(0, 1'b0, 4'd7, 8'h00);

        for (int c = 0; c < 40 && fp_bus.busy; c++) @(posedge clk);
        @(posedge clk); #1;
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        n_ack0 = 0; n_ack1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (fp_bus.ack0) n_ack0++;
            if (fp_bus.ack1) n_ack1++;
        end
        chk("fp_ack0_count", n_ack0, 4);
        chk("fp_ack1_starved", n_ack1, 0);
        @(posedge clk); #1;
        fp_req0 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (fp_bus.ack1) lat = c;
        end
        chk("fp_ack1_latency", lat, 3);
        @(posedge clk); #1;
        fp_req1 = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
